fcw_sweep: RTL and testbench



---
 rtl/fcw_sweep_if.sv | 27 ++
 rtl/fcw_sweep.sv | 118 +++++++++++
 tb/tb_fcw_sweep.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcw_sweep_if.sv
// Sweep controller bus: sweep requests and configuration towards the block,
// frequency control word and status back from it.
interface fcw_sweep_if #(
  parameter int unsigned N = 16,
  parameter int unsigned D = 16
) ();
  logic         start;
  logic         abort;
  logic         mode;
  logic [N-1:0] f_start;
  logic [N-1:0] f_stop;
  logic [N-1:0] f_step;
  logic [D-1:0] dwell;
  logic [N-1:0] fcw;
  logic         busy;
  logic         done;

  modport master (
    output start, abort, mode, f_start, f_stop, f_step, dwell,
    input  fcw, busy, done
  );

  modport slave (
    input  start, abort, mode, f_start, f_stop, f_step, dwell,
    output fcw, busy, done
  );
endinterface

// File: rtl/fcw_sweep.sv
// Linear frequency-sweep (chirp) controller driving an NCO frequency control
// word. Steps fcw from f_start towards f_stop, holding each value dwell+1
// cycles, in single-shot or continuous mode, with abort.
module fcw_sweep #(
  parameter int unsigned N = 16,
  parameter int unsigned D = 16
) (
  input  logic        clk,
  input  logic        reset,
  fcw_sweep_if.slave  bus
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] fcw_q, fcw_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [D-1:0] cnt_q, cnt_d;
  logic [N-1:0] start_l_q, start_l_d;
  logic [N-1:0] stop_l_q, stop_l_d;
  logic [N-1:0] step_l_q, step_l_d;
  logic [D-1:0] dwell_l_q, dwell_l_d;
  logic         mode_l_q, mode_l_d;

  // One extra bit so a step past the top of the range is seen as overshoot
  // and clamped instead of wrapping.
  logic [N:0] next_sum;
  assign next_sum = {1'b0, fcw_q} + {1'b0, step_l_q};

  // Next-state and registered-output logic; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    fcw_d     = fcw_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    start_l_d = start_l_q;
    stop_l_d  = stop_l_q;
    step_l_d  = step_l_q;
    dwell_l_d = dwell_l_q;
    mode_l_d  = mode_l_q;

    if (bus.abort) begin
      state_d = StIdle;
      fcw_d   = '0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            start_l_d = bus.f_start;
            stop_l_d  = bus.f_stop;
            step_l_d  = bus.f_step;
            dwell_l_d = bus.dwell;
            mode_l_d  = bus.mode;
            fcw_d     = bus.f_start;
            cnt_d     = bus.dwell;
            busy_d    = 1'b1;
            state_d   = StRun;
          end
        end
        StRun: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - D'(1);
          end else if (fcw_q < stop_l_q) begin
            fcw_d = (next_sum > {1'b0, stop_l_q}) ? stop_l_q : next_sum[N-1:0];
            cnt_d = dwell_l_q;
          end else if (mode_l_q) begin
            // Continuous: restart the pass, fcw jumps back to the start value.
            fcw_d  = start_l_q;
            cnt_d  = dwell_l_q;
            done_d = 1'b1;
          end else begin
            // Single-shot: last value stays on the NCO after the pass.
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      fcw_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      start_l_q <= '0;
      stop_l_q  <= '0;
      step_l_q  <= '0;
      dwell_l_q <= '0;
      mode_l_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcw_q     <= fcw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      start_l_q <= start_l_d;
      stop_l_q  <= stop_l_d;
      step_l_q  <= step_l_d;
      dwell_l_q <= dwell_l_d;
      mode_l_q  <= mode_l_d;
    end
  end

  assign bus.fcw  = fcw_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_fcw_sweep.sv
// Self-checking bench for fcw_sweep: directed scenarios plus randomized
// sweeps, checked against a list-of-values model of each sweep pass.
module tb_fcw_sweep;

  localparam int unsigned N = 16;
  localparam int unsigned D = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fcw_sweep_if #(.N(N), .D(D)) bus ();

  fcw_sweep #(.N(N), .D(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned total = 0;
  int unsigned bad = 0;

  // Model: the distinct fcw values of one pass, the dwell and the mode.
  int vals_q[$];
  int cfg_dwell;
  bit cfg_mode;
  bit cfg_inf;

  function automatic void build_model(int s, int e, int st, int dw, bit m);
    int v;
    vals_q.delete();
    cfg_dwell = dw;
    cfg_mode  = m;
    cfg_inf   = 1'b0;
    v = s;
    vals_q.push_back(v);
    if (st == 0 && s < e) begin
      cfg_inf = 1'b1;
      return;
    end
    while (v < e) begin
      v = v + st;
      if (v > e) v = e;
      vals_q.push_back(v);
    end
  endfunction

  function automatic int pass_len();
    return vals_q.size() * (cfg_dwell + 1);
  endfunction

  // k counts cycles after the accepting start edge (k=0 shows f_start).
  function automatic logic [N-1:0] exp_fcw(int k);
    int h = cfg_dwell + 1;
    int t = pass_len();
    if (cfg_inf) return N'(vals_q[0]);
    if (cfg_mode) return N'(vals_q[(k % t) / h]);
    if (k < t) return N'(vals_q[k / h]);
    return N'(vals_q[vals_q.size() - 1]);
  endfunction

  function automatic logic exp_busy(int k);
    if (cfg_inf || cfg_mode) return 1'b1;
    return k < pass_len();
  endfunction

  function automatic logic exp_done(int k);
    if (cfg_inf) return 1'b0;
    if (cfg_mode) return (k > 0) && (k % pass_len() == 0);
    return k == pass_len();
  endfunction

  // Drives a start pulse with a configuration; returns at the k=0 sample point.
  task automatic kick(input bit m, input int s, input int e, input int st, input int dw);
    @(negedge clk);
    bus.mode    = m;
    bus.f_start = N'(s);
    bus.f_stop  = N'(e);
    bus.f_step  = N'(st);
    bus.dwell   = D'(dw);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    build_model(s, e, st, dw, m);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.fcw !== '0) begin bad++; $display("FAIL reset_fcw got=%h want=0", bus.fcw); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
  endtask

  task automatic test_basic();
    kick(1'b0, 100, 130, 10, 2);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (bus.fcw !== exp_fcw(k)) begin
        bad++; $display("FAIL basic_fcw k=%0d got=%0d want=%0d", k, bus.fcw, exp_fcw(k));
      end
      total++;
      if (bus.busy !== exp_busy(k)) begin
        bad++; $display("FAIL basic_busy k=%0d got=%b want=%b", k, bus.busy, exp_busy(k));
      end
      total++;
      if (bus.done !== exp_done(k)) begin
        bad++; $display("FAIL basic_done k=%0d got=%b want=%b", k, bus.done, exp_done(k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clamp_wrap();
    int cfg[2][3] = '{'{100, 125, 10}, '{32'hFFF0, 32'hFFFF, 32'h0020}};
    for (int c = 0; c < 2; c++) begin
      kick(1'b0, cfg[c][0], cfg[c][1], cfg[c][2], 0);
      for (int k = 0; k < pass_len() + 3; k++) begin
        total++;
        if (bus.fcw !== exp_fcw(k)) begin
          bad++; $display("FAIL clamp_fcw c=%0d k=%0d got=%h want=%h", c, k, bus.fcw, exp_fcw(k));
        end
        total++;
        if (bus.done !== exp_done(k) || bus.busy !== exp_busy(k)) begin
          bad++;
          $display("FAIL clamp_flags c=%0d k=%0d got=%b%b want=%b%b", c, k,
                   bus.busy, bus.done, exp_busy(k), exp_done(k));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_continuous();
    kick(1'b1, 10, 30, 10, 1);
    for (int k = 0; k < 20; k++) begin
      total++;
      if (bus.fcw !== exp_fcw(k)) begin
        bad++; $display("FAIL cont_fcw k=%0d got=%0d want=%0d", k, bus.fcw, exp_fcw(k));
      end
      total++;
      if (bus.busy !== 1'b1 || bus.done !== exp_done(k)) begin
        bad++;
        $display("FAIL cont_flags k=%0d got=%b%b want=1%b", k, bus.busy, bus.done, exp_done(k));
      end
      // Config inputs move and a stray start arrives while busy: both ignored.
      bus.f_start = N'($urandom_range(0, 500));
      bus.f_stop  = N'($urandom_range(0, 500));
      bus.start   = (k == 4 || k == 11) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  task automatic test_abort();
    int wait_n;
    // Abort mid-sweep.
    kick(1'b0, 100, 200, 5, 1);
    wait_n = $urandom_range(1, 10);
    repeat (wait_n) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bus.fcw !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL abort_run k=%0d got fcw=%0d busy=%b done=%b want 0/0/0",
                 k, bus.fcw, bus.busy, bus.done);
      end
      @(negedge clk);
    end
    // Abort on the end-of-pass edge suppresses done.
    kick(1'b0, 1, 3, 1, 0);
    repeat (pass_len() - 1) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++;
    if (bus.fcw !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL abort_end got fcw=%0d busy=%b done=%b want 0/0/0",
               bus.fcw, bus.busy, bus.done);
    end
    // Start and abort together while idle: stays idle.
    bus.f_start = N'(77);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus.fcw !== '0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL abort_start k=%0d got fcw=%0d busy=%b want 0/0", k, bus.fcw, bus.busy);
      end
      @(negedge clk);
    end
    // Abort while idle clears a persisting tone.
    kick(1'b0, 40, 40, 1, 0);
    repeat (3) @(negedge clk);
    total++;
    if (bus.fcw !== N'(40)) begin bad++; $display("FAIL tone_hold got=%0d want=40", bus.fcw); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++;
    if (bus.fcw !== '0) begin bad++; $display("FAIL abort_idle got=%0d want=0", bus.fcw); end
  endtask

  task automatic test_reset_mid();
    kick(1'b0, 100, 130, 10, 2);
    repeat (3) @(negedge clk);
    total++;
    if (bus.fcw !== N'(110)) begin bad++; $display("FAIL pre_reset got=%0d want=110", bus.fcw); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (bus.fcw !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got fcw=%0d busy=%b done=%b want 0/0/0", bus.fcw, bus.busy, bus.done);
    end
    kick(1'b0, 100, 130, 10, 2);
    for (int k = 0; k < 14; k++) begin
      total++;
      if (bus.fcw !== exp_fcw(k) || bus.busy !== exp_busy(k) || bus.done !== exp_done(k)) begin
        bad++;
        $display("FAIL fresh_sweep k=%0d got %0d/%b/%b want %0d/%b/%b", k, bus.fcw, bus.busy,
                 bus.done, exp_fcw(k), exp_busy(k), exp_done(k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_degenerate();
    kick(1'b0, 50, 40, 7, 3);
    for (int k = 0; k < 7; k++) begin
      total++;
      if (bus.fcw !== exp_fcw(k) || bus.busy !== exp_busy(k) || bus.done !== exp_done(k)) begin
        bad++;
        $display("FAIL degen_down k=%0d got %0d/%b/%b want %0d/%b/%b", k, bus.fcw, bus.busy,
                 bus.done, exp_fcw(k), exp_busy(k), exp_done(k));
      end
      @(negedge clk);
    end
    // Continuous, dwell 0, single-value pass: done every cycle.
    kick(1'b1, 9, 9, 3, 0);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (bus.fcw !== N'(9) || bus.done !== exp_done(k)) begin
        bad++;
        $display("FAIL degen_cont k=%0d got %0d/%b want 9/%b", k, bus.fcw, bus.done, exp_done(k));
      end
      @(negedge clk);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    kick(1'b0, 5, 9, 0, 1);
    for (int k = 0; k < 40; k++) begin
      total++;
      if (bus.fcw !== N'(5) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL zero_step k=%0d got %0d/%b/%b want 5/1/0", k, bus.fcw, bus.busy, bus.done);
      end
      @(negedge clk);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++;
    if (bus.fcw !== '0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL zero_step_abort got %0d/%b want 0/0", bus.fcw, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    kick(1'b0, 20, 50, 15, 1);
    t = pass_len();
    for (int k = 0; k <= t; k++) begin
      total++;
      if (bus.fcw !== exp_fcw(k) || bus.busy !== exp_busy(k) || bus.done !== exp_done(k)) begin
        bad++;
        $display("FAIL b2b_first k=%0d got %0d/%b/%b want %0d/%b/%b", k, bus.fcw, bus.busy,
                 bus.done, exp_fcw(k), exp_busy(k), exp_done(k));
      end
      if (k == t - 1) begin
        // Held through the end-of-pass edge, accepted on the next one.
        bus.mode    = 1'b0;
        bus.f_start = N'(300);
        bus.f_stop  = N'(320);
        bus.f_step  = N'(20);
        bus.dwell   = D'(0);
        bus.start   = 1'b1;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    build_model(300, 320, 20, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bus.fcw !== exp_fcw(k) || bus.busy !== exp_busy(k) || bus.done !== exp_done(k)) begin
        bad++;
        $display("FAIL b2b_second k=%0d got %0d/%b/%b want %0d/%b/%b", k, bus.fcw, bus.busy,
                 bus.done, exp_fcw(k), exp_busy(k), exp_done(k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int s, e, st, dw, n;
    bit m;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = 65535 - int'($urandom_range(0, 60));
        e = 65535 - int'($urandom_range(0, 20));
      end else begin
        s = $urandom_range(0, 300);
        e = $urandom_range(0, 300);
      end
      st = $urandom_range(5, 80);
      dw = $urandom_range(0, 3);
      m  = 1'($urandom_range(0, 1));
      kick(m, s, e, st, dw);
      n = m ? 2 * pass_len() + 3 : pass_len() + 2;
      for (int k = 0; k < n; k++) begin
        total++;
        if (bus.fcw !== exp_fcw(k) || bus.busy !== exp_busy(k) || bus.done !== exp_done(k)) begin
          bad++;
          $display("FAIL rand it=%0d k=%0d got %0d/%b/%b want %0d/%b/%b", it, k, bus.fcw,
                   bus.busy, bus.done, exp_fcw(k), exp_busy(k), exp_done(k));
        end
        // Random stray starts with scrambled config only while busy.
        bus.start   = (m || k < pass_len()) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.f_start = N'($urandom);
        bus.dwell   = D'($urandom_range(0, 7));
        @(negedge clk);
      end
      bus.start = 1'b0;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.mode    = 1'b0;
    bus.f_start = '0;
    bus.f_stop  = '0;
    bus.f_step  = '0;
    bus.dwell   = '0;
    test_reset();
    test_basic();
    test_clamp_wrap();
    test_continuous();
    test_abort();
    test_reset_mid();
    test_degenerate();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
